braille_cell_scheduler: RTL
===========================

Name: braille_cell_scheduler

Overview:
Front-end controller for the serial braille-digit decoder. It accepts whole 6-dot cells from NREQ independent requesters and grants them round-robin. For each granted cell it resets the decoder, shifts the 6 dots into the decoder's serial input, and samples the decoder's 8-bit ASCII output on the final dot. The result is returned with the requester id and an error flag through a valid/ready output port, so one decoder instance is shared by all requesters.

Parameters:
NREQ, 4, number of requesters (2..8).
IDW, 3, width of requester id field; must satisfy 2**IDW >= NREQ.

Ports:
CLK  in  1  clock; all state updates on rising edge.
R  in  1  reset; asynchronous, active-low.
req_valid  in  NREQ  per-requester cell-valid.
req_cell  in  6*NREQ  cell of requester i at bits [6i+5:6i]; bit 5 = dot1, bit 0 = dot6.
req_ready  out  NREQ  one-hot grant/accept strobe.
dec_rst_n  out  1  drives decoder R (active-low).
dec_bit  out  1  drives decoder serial input I.
dec_y  in  8  decoder ASCII output Y; combinational, valid during the dot6 cycle.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts result.
out_ascii  out  8  sampled ASCII code.
out_id  out  IDW  index of the requester that supplied the cell.
out_err  out  1  1 when the sampled dec_y == 8'h00 (pattern not a digit).
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (R low, asynchronous):
  - state = IDLE.
  - out_valid = 0, out_ascii = 0, out_id = 0, out_err = 0.
  - dec_rst_n = 0, dec_bit = 0, req_ready = 0.
  - bit_cnt = 0, rr_ptr = NREQ-1, so requester 0 has highest priority first.
  - Reset mid-shift or mid-hold discards the cell and any pending result. There is no partial output.
- FSM states: IDLE, DRST, SHIFT, HOLD.
- IDLE:
  - dec_rst_n = 1, dec_bit = 0.
  - If any req_valid is set, the grant goes to the first set bit searching from rr_ptr+1 modulo NREQ.
  - req_ready[g] = 1 combinationally in this cycle only.
  - On the clock edge: latch req_cell[g] into shreg and g into id_reg; rr_ptr <= g; go to DRST.
  - If no req_valid is set, stay in IDLE with req_ready = 0.
- DRST (1 cycle): dec_rst_n = 0, dec_bit = 0. Forces the decoder to its start state regardless of leftover state. Go to SHIFT with bit_cnt = 0.
- SHIFT (6 cycles):
  - dec_rst_n = 1, dec_bit = shreg[5-bit_cnt]; dot1 goes first.
  - bit_cnt increments on each edge.
  - On the edge that ends bit_cnt == 5: out_ascii <= dec_y, out_err <= (dec_y == 0), out_id <= id_reg, out_valid <= 1; go to HOLD.
- HOLD:
  - dec_rst_n = 1, dec_bit = 0; outputs stable.
  - While out_ready = 0, stay in HOLD.
  - On an edge with out_ready = 1: out_valid <= 0; go to IDLE.
  - out_ascii, out_id and out_err hold their last values after the handshake.
- Timing:
  - Latency from acceptance edge to out_valid = 7 cycles (DRST + 6 SHIFT).
  - Minimum period per cell = 9 cycles (IDLE, DRST, 6 SHIFT, HOLD with out_ready = 1).
- req_ready is asserted only in IDLE.
  - A requester must hold req_valid and req_cell stable until it sees req_ready.
  - Deasserting req_valid before the grant withdraws the request.
  - Changes to req_cell after acceptance are ignored.
- Fairness: a requester that keeps req_valid asserted is granted within NREQ grants. rr_ptr updates only on a grant.
- out_err cells are reported like any other result, with out_ascii = 8'h00. The FSM does not stall or retry.

Test Plan:
- Single cell, 001111 from req 0 with out_ready = 1 -> req_ready[0] one cycle; dec_rst_n low for 1 cycle; dec_bit sequence 0,0,1,1,1,1; out_valid 7 cycles after acceptance, held 1 cycle; out_ascii = 8'h37 ('7'), out_id = 0, out_err = 0.
- Digit sweep, cells 001000, 000111, 000110, 001101, 001010 -> out_ascii 8'h31, 8'h30, 8'h39, 8'h34, 8'h38 in order; out_err = 0 each.
- Invalid cell 000000 -> out_ascii = 8'h00, out_err = 1; the next valid cell 001111 still decodes to 8'h37. This proves the DRST realignment.
- Round-robin, all 4 requesters valid continuously -> grant order 0,1,2,3,0; out_id follows the same order; no requester is granted twice before the others.
- Backpressure: hold out_ready = 0 for 20 cycles with req 1 pending -> out_valid, out_ascii and out_id stay stable; req_ready stays 0; req 1 is granted the cycle after the out_ready handshake returns the FSM to IDLE.
- Reset during SHIFT at bit_cnt = 3 -> out_valid = 0, dec_rst_n = 0, busy = 0 immediately; after R is released, req 0 has priority and the next cell decodes correctly.

Source files
------------

// File: rtl/braille_cell_scheduler.sv
// Round-robin front end that shares one serial braille-digit decoder among NREQ requesters.
// Latency: 7 cycles from the acceptance edge to out_valid; minimum 9 cycles per cell.
// Backpressure: the result is held in HOLD until out_ready; req_ready is only offered in IDLE.
module braille_cell_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic                CLK,
  input  logic                R,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [6*NREQ-1:0]   req_cell,
  output logic [NREQ-1:0]     req_ready,
  output logic                dec_rst_n,
  output logic                dec_bit,
  input  logic [7:0]          dec_y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_ascii,
  output logic [IDW-1:0]      out_id,
  output logic                out_err,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, DRST, SHIFT, HOLD} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      bit_cnt;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  id_reg;
  logic [5:0]      shreg;
  logic            grant_any;
  logic [IDW-1:0]  grant_idx;
  logic [5:0]      grant_cell;

  // Round-robin pick: lowest requester above rr_ptr wins, else lowest at or below it.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (IDW'(i) <= rr_ptr)) begin
        grant_any = 1'b1;
        grant_idx = IDW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (IDW'(i) > rr_ptr)) begin
        grant_any = 1'b1;
        grant_idx = IDW'(i);
      end
    end
  end

  // Select the cell presented by the winning requester.
  always_comb begin
    grant_cell = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) grant_cell = req_cell[6*i +: 6];
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) state <= IDLE;
    else    state <= state_nxt;
  end

  // Next-state logic: one DRST cycle, six SHIFT cycles, then HOLD until the consumer takes it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = DRST;
      DRST:    state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 3'd5) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; R gates the decoder reset and grant so both drop the instant reset asserts.
  always_comb begin
    req_ready = '0;
    dec_rst_n = 1'b0;
    dec_bit   = 1'b0;
    busy      = (state != IDLE);
    if (R) begin
      case (state)
        IDLE: begin
          dec_rst_n = 1'b1;
          for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_any && (grant_idx == IDW'(i));
          end
        end
        DRST:    dec_rst_n = 1'b0;
        SHIFT: begin
          dec_rst_n = 1'b1;
          dec_bit   = shreg[3'd5 - bit_cnt];
        end
        default: dec_rst_n = 1'b1;
      endcase
    end
  end

  // Datapath: latch the granted cell, count dots, capture the decoder result on dot6.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      bit_cnt   <= 3'd0;
      rr_ptr    <= IDW'(NREQ - 1);
      id_reg    <= '0;
      shreg     <= '0;
      out_valid <= 1'b0;
      out_ascii <= 8'h00;
      out_id    <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            shreg  <= grant_cell;
            id_reg <= grant_idx;
            rr_ptr <= grant_idx;
          end
        end
        DRST: bit_cnt <= 3'd0;
        SHIFT: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd5) begin
            out_ascii <= dec_y;
            out_err   <= (dec_y == 8'h00);
            out_id    <= id_reg;
            out_valid <= 1'b1;
          end
        end
        HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
